// File: rtl/coeff_mem_pkg.sv
// Shared types and constants for the coefficient-memory arbiter.
package coeff_mem_pkg;

   // Controller sequencing states.
   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WRITE     = 2'd1,
      READ      = 2'd2,
      READ_WAIT = 2'd3
   } cm_state_t;

   // Identity of the requester that won most recently.
   typedef enum logic {
      LOADER = 1'b0,
      WALKER = 1'b1
   } cm_grant_t;

   // Bit positions of each requester inside the req/gnt vectors.
   localparam int GNT_LD = 0;
   localparam int GNT_WK = 1;

   // Cycles from handshake to wk_rvalid, and cycles a write occupies the port.
   localparam int READ_LATENCY    = 3;
   localparam int WRITE_OCCUPANCY = 2;

endpackage

// File: rtl/coeff_mem_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter with a one-hot combinational grant.
// Bit 0 is the loader, bit 1 the walker. On a tie the requester that did
// not win last time is granted; the history updates when en is high.
module rr_arb2
   import coeff_mem_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       en,
   output logic [1:0] gnt
);

   cm_grant_t last_grant_reg;

   // Lone requester wins; on a tie the one not granted last time wins.
   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = (last_grant_reg == WALKER) ? 2'b01 : 2'b10;
         default: gnt = 2'b00;
      endcase
   end

   // Record the winner of every consumed grant; walker after reset so the loader wins the first tie.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_grant_reg <= WALKER;
      end else if (en && (gnt != 2'b00)) begin
         last_grant_reg <= gnt[GNT_WK] ? WALKER : LOADER;
      end
   end

endmodule

// File: rtl/coeff_mem_arbiter.sv
// Shares the single-port coefficient memory between the configuration
// loader (writes) and the tree walker (reads). Requests are accepted only
// in IDLE. A write strobes the memory for one cycle; a read strobes it for
// one cycle, waits one cycle for the memory to drive the bus, then captures
// the word and pulses wk_rvalid. Out-of-range addresses are accepted but
// never reach the memory; they pulse err (and wk_rvalid with zero data for
// reads) on the following cycle.
module coeff_mem_arbiter
   import coeff_mem_pkg::*;
#(
   parameter  int DEPTH = 24,
   parameter  int WORDS = 8,
   localparam int AW    = $clog2(WORDS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ld_valid,
   output logic             ld_ready,
   input  logic [AW-1:0]    ld_addr,
   input  logic [DEPTH-1:0] ld_data,
   input  logic             wk_valid,
   output logic             wk_ready,
   input  logic [AW-1:0]    wk_addr,
   output logic             wk_rvalid,
   output logic [DEPTH-1:0] wk_rdata,
   output logic             err,
   output logic             mem_ce,
   output logic             mem_we,
   output logic [AW-1:0]    mem_a,
   inout  wire  [DEPTH-1:0] mem_d
);

   // One extra bit so the address compare also works when WORDS is a power of two.
   localparam logic [AW:0] WORDS_LIM = WORDS[AW:0];

   cm_state_t        state_reg, state_next;
   logic             mem_ce_reg, mem_ce_next;
   logic             mem_we_reg, mem_we_next;
   logic [AW-1:0]    mem_a_reg, mem_a_next;
   logic [DEPTH-1:0] wdata_reg, wdata_next;
   logic [DEPTH-1:0] rdata_reg, rdata_next;
   logic             rvalid_reg, rvalid_next;
   logic             err_reg, err_next;

   logic [1:0]       req;
   logic [1:0]       gnt;
   logic             is_idle;
   logic             ld_hs;
   logic             wk_hs;
   logic             ld_in_range;
   logic             wk_in_range;

   assign is_idle = (state_reg == IDLE);

   assign req[GNT_LD] = ld_valid;
   assign req[GNT_WK] = wk_valid;

   rr_arb2 u_arb (
      .clk   (clk),
      .reset (reset),
      .req   (req),
      .en    (is_idle),
      .gnt   (gnt)
   );

   // Grants are only offered while the port is free.
   assign ld_ready = is_idle && gnt[GNT_LD];
   assign wk_ready = is_idle && gnt[GNT_WK];

   assign ld_hs = ld_valid && ld_ready;
   assign wk_hs = wk_valid && wk_ready;

   assign ld_in_range = ({1'b0, ld_addr} < WORDS_LIM);
   assign wk_in_range = ({1'b0, wk_addr} < WORDS_LIM);

   // Next-state and next-strobe logic; strobes default low so each lasts exactly one state.
   always_comb begin
      state_next  = state_reg;
      mem_ce_next = 1'b0;
      mem_we_next = 1'b0;
      mem_a_next  = mem_a_reg;
      wdata_next  = wdata_reg;
      rdata_next  = rdata_reg;
      rvalid_next = 1'b0;
      err_next    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (ld_hs) begin
               if (ld_in_range) begin
                  state_next  = WRITE;
                  mem_ce_next = 1'b1;
                  mem_we_next = 1'b1;
                  mem_a_next  = ld_addr;
                  wdata_next  = ld_data;
               end else begin
                  err_next = 1'b1;
               end
            end else if (wk_hs) begin
               if (wk_in_range) begin
                  state_next  = READ;
                  mem_ce_next = 1'b1;
                  mem_a_next  = wk_addr;
               end else begin
                  err_next    = 1'b1;
                  rvalid_next = 1'b1;
                  rdata_next  = '0;
               end
            end
         end
         WRITE: begin
            state_next = IDLE;
         end
         READ: begin
            state_next = READ_WAIT;
         end
         READ_WAIT: begin
            // The memory is driving the bus now; take the word on the way out.
            state_next  = IDLE;
            rdata_next  = mem_d;
            rvalid_next = 1'b1;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State and output registers; reset drops any transaction in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg  <= IDLE;
         mem_ce_reg <= 1'b0;
         mem_we_reg <= 1'b0;
         mem_a_reg  <= '0;
         wdata_reg  <= '0;
         rdata_reg  <= '0;
         rvalid_reg <= 1'b0;
         err_reg    <= 1'b0;
      end else begin
         state_reg  <= state_next;
         mem_ce_reg <= mem_ce_next;
         mem_we_reg <= mem_we_next;
         mem_a_reg  <= mem_a_next;
         wdata_reg  <= wdata_next;
         rdata_reg  <= rdata_next;
         rvalid_reg <= rvalid_next;
         err_reg    <= err_next;
      end
   end

   assign mem_ce    = mem_ce_reg;
   assign mem_we    = mem_we_reg;
   assign mem_a     = mem_a_reg;
   assign wk_rvalid = rvalid_reg;
   assign wk_rdata  = rdata_reg;
   assign err       = err_reg;

   // Drive the bus only while writing; the enable comes from the strobe
   // registers themselves, so it can never overlap the memory's read cycle.
   assign mem_d = (mem_ce_reg && mem_we_reg) ? wdata_reg : {DEPTH{1'bz}};

endmodule

// File: tb/tb_coeff_mem_arbiter.sv
// Randomized self-checking bench for coeff_mem_arbiter (WORDS=6 so that
// addresses 6 and 7 exercise the out-of-range path). A transaction-level
// scoreboard predicts grants, strobes, bus contents and read returns.
module tb_coeff_mem_arbiter;

   localparam int DEPTH = 24;
   localparam int WORDS = 6;
   localparam int AW    = $clog2(WORDS);
   localparam logic [DEPTH-1:0] ALL1 = {DEPTH{1'b1}};

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             ld_valid = 1'b0;
   logic             ld_ready;
   logic [AW-1:0]    ld_addr = '0;
   logic [DEPTH-1:0] ld_data = '0;
   logic             wk_valid = 1'b0;
   logic             wk_ready;
   logic [AW-1:0]    wk_addr = '0;
   logic             wk_rvalid;
   logic [DEPTH-1:0] wk_rdata;
   logic             err;
   logic             mem_ce;
   logic             mem_we;
   logic [AW-1:0]    mem_a;
   wire  [DEPTH-1:0] mem_d;

   int n_checks = 0;
   int n_errors = 0;

   coeff_mem_arbiter #(.DEPTH(DEPTH), .WORDS(WORDS)) dut (
      .clk       (clk),
      .reset     (reset),
      .ld_valid  (ld_valid),
      .ld_ready  (ld_ready),
      .ld_addr   (ld_addr),
      .ld_data   (ld_data),
      .wk_valid  (wk_valid),
      .wk_ready  (wk_ready),
      .wk_addr   (wk_addr),
      .wk_rvalid (wk_rvalid),
      .wk_rdata  (wk_rdata),
      .err       (err),
      .mem_ce    (mem_ce),
      .mem_we    (mem_we),
      .mem_a     (mem_a),
      .mem_d     (mem_d)
   );

   always #5 clk = ~clk;

   // Undriven bus reads as all ones.
   pullup pu_bus (mem_d);

   function automatic logic [DEPTH-1:0] init_word(input int i);
      return 24'h5A0000 + 24'(i) * 24'h000111;
   endfunction

   // ---------------- synchronous single-port memory model ----------------
   logic [DEPTH-1:0] mem_arr [0:7];
   logic [DEPTH-1:0] mem_q = '0;
   logic             mem_oe = 1'b0;
   logic             preloaded = 1'b0;

   always @(posedge clk) begin
      if (!preloaded) begin
         for (int i = 0; i < 8; i++) mem_arr[i] <= init_word(i);
         preloaded <= 1'b1;
      end else if (mem_ce && mem_we) begin
         mem_arr[mem_a] <= mem_d;
      end
      mem_oe <= mem_ce && !mem_we;
      if (mem_ce && !mem_we) mem_q <= mem_arr[mem_a];
   end

   assign mem_d = (mem_oe && reset) ? mem_q : {DEPTH{1'bz}};

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- scoreboard ----------------
   logic [DEPTH-1:0] ref_mem [0:7];
   logic             s_ce  [16];
   logic             s_we  [16];
   logic             s_drv [16];
   logic             s_rv  [16];
   logic             s_err [16];
   logic [AW-1:0]    s_a   [16];
   logic [DEPTH-1:0] s_bus [16];
   logic [DEPTH-1:0] s_rd  [16];
   logic             ld_acc = 1'b0;
   logic             wk_acc = 1'b0;
   int               txn = 0;

   task automatic clear_slot(input int k);
      s_ce[k] = 0; s_we[k] = 0; s_drv[k] = 0; s_rv[k] = 0; s_err[k] = 0;
      s_a[k] = '0; s_bus[k] = '0; s_rd[k] = '0;
   endtask

   initial begin
      int cyc;
      int busy_until;
      int k, k1, k2, k3;
      logic last_walker;
      logic gl, gw;
      logic [DEPTH-1:0] rdata_hold;
      cyc = 0; busy_until = 0; last_walker = 1'b1; rdata_hold = '0;
      for (int i = 0; i < 8; i++) ref_mem[i] = init_word(i);
      for (int i = 0; i < 16; i++) clear_slot(i);
      forever begin
         @(negedge clk);
         k  = cyc % 16;
         k1 = (cyc + 1) % 16;
         k2 = (cyc + 2) % 16;
         k3 = (cyc + 3) % 16;
         if (!reset) begin
            chk("rst_mem_ce", mem_ce, 0);
            chk("rst_mem_we", mem_we, 0);
            chk("rst_mem_a", mem_a, 0);
            chk("rst_rvalid", wk_rvalid, 0);
            chk("rst_rdata", wk_rdata, 0);
            chk("rst_err", err, 0);
            chk("rst_bus_z", mem_d, ALL1);
            chk("rst_ld_ready", ld_ready, 0);
            chk("rst_wk_ready", wk_ready, 0);
            for (int i = 0; i < 16; i++) clear_slot(i);
            busy_until = 0; last_walker = 1'b1; rdata_hold = '0;
            ld_acc = 1'b0; wk_acc = 1'b0;
         end else begin
            chk("mem_ce", mem_ce, s_ce[k]);
            if (s_ce[k]) begin
               chk("mem_we", mem_we, s_we[k]);
               chk("mem_a", mem_a, s_a[k]);
            end
            if (s_drv[k]) chk("mem_d", mem_d, s_bus[k]);
            else          chk("mem_d_z", mem_d, ALL1);
            chk("wk_rvalid", wk_rvalid, s_rv[k]);
            chk("err", err, s_err[k]);
            if (s_rv[k]) rdata_hold = s_rd[k];
            chk("wk_rdata", wk_rdata, rdata_hold);
            clear_slot(k);

            gl = 1'b0; gw = 1'b0;
            if (cyc >= busy_until) begin
               if (ld_valid && wk_valid) begin
                  if (last_walker) gl = 1'b1; else gw = 1'b1;
               end else if (ld_valid) gl = 1'b1;
               else if (wk_valid) gw = 1'b1;
            end
            chk("ld_ready", ld_ready, gl);
            chk("wk_ready", wk_ready, gw);

            if (gl) begin
               last_walker = 1'b0;
               txn++;
               $display("txn %0d: write addr=%0d data=0x%06h", txn, ld_addr, ld_data);
               if (int'(ld_addr) < WORDS) begin
                  s_ce[k1] = 1; s_we[k1] = 1; s_a[k1] = ld_addr;
                  s_drv[k1] = 1; s_bus[k1] = ld_data;
                  ref_mem[ld_addr] = ld_data;
                  busy_until = cyc + 2;
               end else begin
                  s_err[k1] = 1;
                  busy_until = cyc + 1;
               end
            end
            if (gw) begin
               last_walker = 1'b1;
               txn++;
               $display("txn %0d: read  addr=%0d expect=0x%06h", txn, wk_addr,
                        (int'(wk_addr) < WORDS) ? ref_mem[wk_addr] : '0);
               if (int'(wk_addr) < WORDS) begin
                  s_ce[k1] = 1; s_we[k1] = 0; s_a[k1] = wk_addr;
                  s_drv[k2] = 1; s_bus[k2] = ref_mem[wk_addr];
                  s_rv[k3] = 1; s_rd[k3] = ref_mem[wk_addr];
                  busy_until = cyc + 3;
               end else begin
                  s_err[k1] = 1; s_rv[k1] = 1; s_rd[k1] = '0;
                  busy_until = cyc + 1;
               end
            end
            ld_acc = gl;
            wk_acc = gw;
         end
         cyc++;
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [DEPTH-1:0] d);
      int n;
      n = 0;
      ld_valid = 1'b1; ld_addr = a; ld_data = d;
      do begin
         step();
         n++;
      end while (!ld_acc && n < 40);
      chk("ld_handshake", ld_acc, 1);
      ld_valid = 1'b0;
      ld_addr  = AW'($urandom);
      ld_data  = DEPTH'($urandom);
   endtask

   task automatic do_read(input logic [AW-1:0] a);
      int n;
      n = 0;
      wk_valid = 1'b1; wk_addr = a;
      do begin
         step();
         n++;
      end while (!wk_acc && n < 40);
      chk("wk_handshake", wk_acc, 1);
      wk_valid = 1'b0;
      wk_addr  = AW'($urandom);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (3) step();
      reset = 1'b1;
      step();

      // Both requesters from reset: loader first, then strict alternation.
      fork
         begin do_write(3'd0, 24'h111111); do_write(3'd5, 24'h222222); end
         begin do_read(3'd0); do_read(3'd5); end
      join
      repeat (3) step();

      // Load then read back.
      do_write(3'd3, 24'hA5A5A5);
      do_read(3'd3);
      repeat (2) step();
      chk("readback_rvalid", wk_rvalid, 1);
      chk("readback_rdata", wk_rdata, 24'hA5A5A5);

      // Bus turnaround: read immediately followed by a write.
      fork
         do_read(3'd1);
         begin step(); do_write(3'd2, 24'h0F0F0F); end
      join
      repeat (3) step();

      // Out-of-range read and write.
      do_read(3'd7);
      chk("oor_rd_err", err, 1);
      chk("oor_rd_rvalid", wk_rvalid, 1);
      chk("oor_rd_rdata", wk_rdata, 0);
      chk("oor_rd_ce", mem_ce, 0);
      do_write(3'd6, 24'hDEAD01);
      chk("oor_wr_err", err, 1);
      chk("oor_wr_ce", mem_ce, 0);
      step();

      // Back-to-back reads with wk_valid held.
      do_read(3'd0);
      do_read(3'd1);
      do_read(3'd2);
      repeat (4) step();

      // Reset in READ_WAIT drops the read.
      do_read(3'd2);
      step();
      reset = 1'b0;
      #1;
      chk("midrst_ce", mem_ce, 0);
      chk("midrst_rvalid", wk_rvalid, 0);
      chk("midrst_bus_z", mem_d, ALL1);
      repeat (2) step();
      reset = 1'b1;
      do_read(3'd0);
      repeat (2) step();
      chk("postrst_rvalid", wk_rvalid, 1);
      step();

      // Random traffic from both requesters.
      fork
         begin
            repeat (60) begin
               repeat ($urandom_range(0, 2)) step();
               do_write(AW'($urandom_range(0, 7)), DEPTH'($urandom));
            end
         end
         begin
            repeat (60) begin
               repeat ($urandom_range(0, 2)) step();
               do_read(AW'($urandom_range(0, 7)));
            end
         end
      join
      repeat (5) step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
